wb_stage: RTL and testbench

//  Writeback stage of the in-order RV32I pipeline, fed by the MEM stage and the WB decoder
//  (reg_we, reg_sel, load_sel). It registers the retiring instruction, waits for load data

---
 rtl/wb_stage_if.sv | 32 +++
 rtl/wb_stage.sv | 156 +++++++++++++++
 tb/tb_wb_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_stage_if : MEM-to-WB handshake and load-return bus       Rev 1.0      |
// +--------------------------------------------------------------------------+
interface wb_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic            reg_we;
  logic [1:0]      reg_sel;
  logic [2:0]      load_sel;
  logic [XLEN-1:0] res;
  logic [XLEN-1:0] pc_plus_4;
  logic [1:0]      addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output in_valid, inst, reg_we, reg_sel, load_sel, res, pc_plus_4, addr_lo,
           mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, inst, reg_we, reg_sel, load_sel, res, pc_plus_4, addr_lo,
           mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_stage : RV32I writeback stage with load alignment and instret  Rev 1.0|
// +--------------------------------------------------------------------------+
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  wb_stage_if.slave             mem,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  misalign,
  output logic [CNT_W-1:0]      instret
);

  localparam logic [1:0] c_sel_res  = 2'd0;
  localparam logic [1:0] c_sel_mem  = 2'd1;
  localparam logic [1:0] c_sel_pc4  = 2'd2;
  localparam logic [2:0] c_load_h   = 3'd1;
  localparam logic [2:0] c_load_hu  = 3'd2;
  localparam logic [2:0] c_load_b   = 3'd3;
  localparam logic [2:0] c_load_bu  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_in_ready;
  logic                  w_accept;
  logic [REG_ADDR_W-1:0] w_in_rd;
  logic                  w_mis;
  logic [XLEN-1:0]       w_load_val;

  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_we;
  logic [2:0]            r_load_sel;
  logic [1:0]            r_addr_lo;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_mis;
  logic [CNT_W-1:0]      r_instret;

  // Only the rd field of the instruction word matters at writeback.
  logic w_unused_inst;
  assign w_unused_inst = ^{mem.inst[31:12], mem.inst[6:0]};

  function automatic logic [XLEN-1:0] f_extract(input logic [2:0] sel,
                                                input logic [1:0] a,
                                                input logic [XLEN-1:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = d[16*a[1] +: 16];
    b = d[8*a +: 8];
    case (sel)
      c_load_h:  return {{(XLEN-16){h[15]}}, h};
      c_load_hu: return {{(XLEN-16){1'b0}}, h};
      c_load_b:  return {{(XLEN-8){b[7]}}, b};
      c_load_bu: return {{(XLEN-8){1'b0}}, b};
      default:   return d;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [2:0] sel, input logic [1:0] a);
    case (sel)
      c_load_h, c_load_hu: return a[0];
      c_load_b, c_load_bu: return 1'b0;
      default:             return (a != 2'd0);
    endcase
  endfunction

  always_comb begin
    w_in_ready = (r_state != S_WAIT_MEM);
    w_accept   = mem.in_valid & w_in_ready;
    w_in_rd    = mem.inst[11:7];
    w_mis      = f_misaligned(r_load_sel, r_addr_lo);
    w_load_val = f_extract(r_load_sel, r_addr_lo, mem.mem_rdata);
  end

  assign mem.in_ready = w_in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT_MEM: if (mem.mem_rvalid) w_next = S_WRITE;
      S_IDLE, S_WRITE: begin
        if (w_accept) w_next = (mem.reg_sel == c_sel_mem) ? S_WAIT_MEM : S_WRITE;
        else          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Write-port registers are loaded on the edge that enters WRITE, so
  // rf_we can only be high during the WRITE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd       <= '0;
      r_reg_we   <= 1'b0;
      r_load_sel <= '0;
      r_addr_lo  <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_mis      <= 1'b0;
      r_instret  <= '0;
    end else begin
      r_rf_we <= 1'b0;
      r_mis   <= 1'b0;
      if (w_accept) begin
        r_rd       <= w_in_rd;
        r_reg_we   <= mem.reg_we;
        r_load_sel <= mem.load_sel;
        r_addr_lo  <= mem.addr_lo;
      end
      if (w_accept && (mem.reg_sel != c_sel_mem)) begin
        r_rf_we    <= mem.reg_we & (w_in_rd != '0);
        r_rf_waddr <= w_in_rd;
        r_rf_wdata <= (mem.reg_sel == c_sel_pc4) ? mem.pc_plus_4 : mem.res;
      end else if ((r_state == S_WAIT_MEM) && mem.mem_rvalid) begin
        r_rf_we    <= r_reg_we & (r_rd != '0) & ~w_mis;
        r_rf_waddr <= r_rd;
        r_rf_wdata <= w_load_val;
        r_mis      <= w_mis;
      end
      if (r_state == S_WRITE) r_instret <= r_instret + 1'b1;
    end
  end

  assign rf_we     = r_rf_we;
  assign rf_waddr  = r_rf_waddr;
  assign rf_wdata  = r_rf_wdata;
  assign misalign  = r_mis;
  assign instret   = r_instret;
  assign fwd_valid = ((r_state == S_WAIT_MEM) || (r_state == S_WRITE)) & r_reg_we & (r_rd != '0);
  assign fwd_rd    = r_rd;
  assign fwd_data  = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_stage : directed and random checks of wb_stage          Rev 1.0    |
// +--------------------------------------------------------------------------+
module tb_wb_stage;
  logic        clock;
  logic        reset_n;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        misalign;
  logic [63:0] instret;

  int          checks;
  int          errors;
  logic [63:0] exp_instret;

  wb_stage_if #(.XLEN(32)) bus ();

  wb_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(64)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .mem       (bus),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .misalign  (misalign),
    .instret   (instret)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference load result: shift the addressed lane down, mask, sign-adjust.
  function automatic logic [31:0] m_load(input int sel, input int a, input logic [31:0] d);
    logic [31:0] b, h;
    b = (d >> (8 * a)) & 32'hFF;
    h = (d >> (16 * (a / 2))) & 32'hFFFF;
    case (sel)
      1:       return (h >= 32'h8000) ? h - 32'h10000 : h;
      2:       return h;
      3:       return (b >= 32'h80) ? b - 32'h100 : b;
      4:       return b;
      default: return d;
    endcase
  endfunction

  function automatic bit m_mis(input int sel, input int a);
    if (sel == 1 || sel == 2) return (a % 2) != 0;
    if (sel == 3 || sel == 4) return 1'b0;
    return a != 0;
  endfunction

  task automatic drive(input logic [4:0] rd, input logic we, input logic [1:0] rsel,
                       input logic [2:0] lsel, input logic [31:0] res,
                       input logic [31:0] pc4, input logic [1:0] a);
    logic [31:0] iw;
    iw = $urandom;
    iw[11:7] = rd;
    bus.in_valid  = 1'b1;
    bus.inst      = iw;
    bus.reg_we    = we;
    bus.reg_sel   = rsel;
    bus.load_sel  = lsel;
    bus.res       = res;
    bus.pc_plus_4 = pc4;
    bus.addr_lo   = a;
  endtask

  task automatic check_write(input logic [4:0] rd, input logic we, input logic [1:0] rsel,
                             input logic [2:0] lsel, input logic [31:0] res,
                             input logic [31:0] pc4, input logic [1:0] a,
                             input logic [31:0] rdata);
    logic [31:0] val;
    bit          mis;
    bit          wr;
    mis = (rsel == 2'd1) && m_mis(int'(lsel), int'(a));
    val = (rsel == 2'd1) ? m_load(int'(lsel), int'(a), rdata) : (rsel == 2'd2) ? pc4 : res;
    wr  = we && (rd != 0) && !mis;
    check("rf_we", rf_we, wr);
    check("misalign", misalign, mis);
    check("fwd_valid", fwd_valid, we && (rd != 0));
    if (wr) begin
      check("rf_waddr", rf_waddr, rd);
      check("rf_wdata", rf_wdata, val);
      check("fwd_rd", fwd_rd, rd);
      check("fwd_data", fwd_data, val);
    end
    exp_instret++;
  endtask

  task automatic do_op(input logic [4:0] rd, input logic we, input logic [1:0] rsel,
                       input logic [2:0] lsel, input logic [31:0] res,
                       input logic [31:0] pc4, input logic [1:0] a,
                       input logic [31:0] rdata, input int lat);
    drive(rd, we, rsel, lsel, res, pc4, a);
    check("ready_at_accept", bus.in_ready, 1'b1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    if (rsel == 2'd1) begin
      check("wait_ready", bus.in_ready, 1'b0);
      check("wait_rf_we", rf_we, 1'b0);
      check("wait_fwd", fwd_valid, we && (rd != 0));
      repeat (lat) begin
        @(posedge clock); #1;
        check("wait_ready", bus.in_ready, 1'b0);
      end
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = rdata;
      @(posedge clock); #1;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
    end
    check("write_ready", bus.in_ready, 1'b1);
    check_write(rd, we, rsel, lsel, res, pc4, a, rdata);
    @(posedge clock); #1;
    check("idle_rf_we", rf_we, 1'b0);
    check("instret", instret, exp_instret);
  endtask

  logic [4:0]  b2b_rd  [4];
  logic [31:0] b2b_res [4];

  initial begin
    checks = 0;
    errors = 0;
    exp_instret = '0;
    reset_n = 1'b0;
    bus.in_valid = 1'b0; bus.inst = '0; bus.reg_we = 1'b0; bus.reg_sel = '0;
    bus.load_sel = '0; bus.res = '0; bus.pc_plus_4 = '0; bus.addr_lo = '0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    check("rst_fwd_valid", fwd_valid, 1'b0);
    check("rst_instret", instret, 64'h0);
    check("rst_ready", bus.in_ready, 1'b1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // ADDI / LB / LHU / misaligned LW / JAL / ADDI x0
    do_op(5'd5, 1'b1, 2'd0, 3'd0, 32'h1234, 32'h0, 2'd0, 32'h0, 0);
    do_op(5'd3, 1'b1, 2'd1, 3'd3, 32'h0, 32'h0, 2'd2, 32'h0080_0000, 1);
    do_op(5'd9, 1'b1, 2'd1, 3'd2, 32'h0, 32'h0, 2'd2, 32'hBEEF_0000, 0);
    do_op(5'd4, 1'b1, 2'd1, 3'd0, 32'h0, 32'h0, 2'd1, 32'h1111_2222, 2);
    do_op(5'd1, 1'b1, 2'd2, 3'd0, 32'hDEAD, 32'h104, 2'd0, 32'h0, 0);
    do_op(5'd0, 1'b1, 2'd0, 3'd0, 32'h55, 32'h0, 2'd0, 32'h0, 0);
    do_op(5'd6, 1'b1, 2'd3, 3'd0, 32'hCAFE, 32'h200, 2'd0, 32'h0, 0);
    do_op(5'd7, 1'b1, 2'd1, 3'd6, 32'h0, 32'h0, 2'd0, 32'h8765_4321, 0);
    do_op(5'd8, 1'b1, 2'd1, 3'd1, 32'h0, 32'h0, 2'd0, 32'h0000_8001, 3);

    // A stray load-return pulse while idle must not write.
    bus.mem_rvalid = 1'b1;
    @(posedge clock); #1;
    bus.mem_rvalid = 1'b0;
    check("stray_rvalid_we", rf_we, 1'b0);
    check("stray_rvalid_ret", instret, exp_instret);

    // Back-to-back ALU ops: one write per cycle, ready stays high.
    for (int i = 0; i < 4; i++) begin
      b2b_rd[i]  = 5'(i + 10);
      b2b_res[i] = $urandom;
    end
    drive(b2b_rd[0], 1'b1, 2'd0, 3'd0, b2b_res[0], 32'h0, 2'd0);
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      check("b2b_ready", bus.in_ready, 1'b1);
      check_write(b2b_rd[i], 1'b1, 2'd0, 3'd0, b2b_res[i], 32'h0, 2'd0, 32'h0);
      if (i < 3) drive(b2b_rd[i+1], 1'b1, 2'd0, 3'd0, b2b_res[i+1], 32'h0, 2'd0);
      else       bus.in_valid = 1'b0;
      @(posedge clock); #1;
    end
    check("b2b_instret", instret, exp_instret);

    // Randomized mix of ALU, link and load instructions.
    for (int n = 0; n < 40; n++) begin
      do_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            $urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
            int'($urandom_range(0, 3)));
    end

    // Reset while waiting for load data abandons the load.
    drive(5'd12, 1'b1, 2'd1, 3'd0, 32'h0, 32'h0, 2'd0);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    check("pre_rst_ready", bus.in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    exp_instret = '0;
    check("mid_rst_ready", bus.in_ready, 1'b1);
    check("mid_rst_fwd", fwd_valid, 1'b0);
    check("mid_rst_instret", instret, exp_instret);
    check("mid_rst_wdata", rf_wdata, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    bus.mem_rvalid = 1'b0;
    check("late_rvalid_we", rf_we, 1'b0);
    @(posedge clock); #1;
    check("late_rvalid_we2", rf_we, 1'b0);
    check("late_rvalid_mis", misalign, 1'b0);
    check("late_rvalid_ret", instret, exp_instret);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
